// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: 8 lines x 4 bytes, one-block memory port.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [7:0]  HIT_COUNT,
  output logic [7:0]  MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic [2:0]  addr_tag_s;
  logic [2:0]  idx_s;
  logic [1:0]  off_s;
  logic        req_s;
  logic        hit_s;
  logic        fill_s;
  logic        wr_hit_s;
  logic [31:0] line_data_s;

  function automatic logic [7:0] get_byte(input logic [31:0] line, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      2'd3:    b = line[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] line, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] l;
    l = line;
    case (off)
      2'd0:    l[7:0]   = b;
      2'd1:    l[15:8]  = b;
      2'd2:    l[23:16] = b;
      2'd3:    l[31:24] = b;
      default: l = line;
    endcase
    return l;
  endfunction

  assign addr_tag_s  = ADDRESS[7:5];
  assign idx_s       = ADDRESS[4:2];
  assign off_s       = ADDRESS[1:0];
  // READ and WRITE together is not a request; reset also masks the request so BUSYWAIT stays low.
  assign req_s       = (READ ^ WRITE) & ~RESET;
  assign line_data_s = data_q[idx_s];
  assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == addr_tag_s);

  always_comb begin
    if (RESET) begin
      READDATA = 8'd0;
    end else begin
      READDATA = get_byte(line_data_s, off_s);
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    fill_s        = 1'b0;
    wr_hit_s      = 1'b0;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (req_s && hit_s) begin
          if (WRITE) begin
            wr_hit_s        = 1'b1;
            dirty_d[idx_s]  = 1'b1;
          end else begin
            wr_hit_s        = 1'b0;
          end
        end else if (req_s) begin
          BUSYWAIT = 1'b1;
          if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx_s], idx_s};
        MEM_WRITEDATA = line_data_s;
        if (!MEM_BUSYWAIT) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag_s, idx_s};
        if (!MEM_BUSYWAIT) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_UPDATE: begin
        BUSYWAIT       = 1'b1;
        fill_s         = 1'b1;
        valid_d[idx_s] = 1'b1;
        dirty_d[idx_s] = 1'b0;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= 8'd0;
      dirty_q <= 8'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line payload needs no reset: valid bits guard it.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      data_q[idx_s] <= MEM_READDATA;
      tag_q[idx_s]  <= addr_tag_s;
    end else if (wr_hit_s) begin
      data_q[idx_s] <= put_byte(line_data_s, off_s, WRITEDATA);
    end
  end

`ifdef DCACHE_STATS_EN
  logic       hit_evt_s;
  logic       miss_evt_s;
  logic [7:0] hit_cnt_q;
  logic [7:0] miss_cnt_q;

  assign hit_evt_s  = (state_q == S_IDLE) && req_s && hit_s;
  assign miss_evt_s = (state_q == S_IDLE) && req_s && !hit_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= 8'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      if (hit_evt_s && (hit_cnt_q != 8'hFF)) begin
        hit_cnt_q <= hit_cnt_q + 8'd1;
      end else begin
        hit_cnt_q <= hit_cnt_q;
      end
      if (miss_evt_s && (miss_cnt_q != 8'hFF)) begin
        miss_cnt_q <= miss_cnt_q + 8'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a fixed-latency block memory model.
module tb_dcache_ctrl;

  localparam int MEM_LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'd0;
  logic        MEM_BUSYWAIT = 1'b1;
`ifdef DCACHE_STATS_EN
  logic [7:0]  HIT_COUNT;
  logic [7:0]  MISS_COUNT;
`endif

  int          errors = 0;
  int          checks = 0;
  int          mcnt = 0;
  logic [31:0] mem_rdata_v;

  int          bw;
  int          first_w;
  int          first_r;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [5:0]  ra;
  logic        both;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory answers on the MEM_LAT-th cycle a strobe is seen high.
  always @(negedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (mcnt == MEM_LAT - 1) begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_rdata_v;
        mcnt = 0;
      end else begin
        MEM_BUSYWAIT = 1'b1;
        mcnt = mcnt + 1;
      end
    end else begin
      MEM_BUSYWAIT = 1'b1;
      mcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts stall cycles (current one included) and records memory traffic until BUSYWAIT drops.
  task automatic wait_fill(output int o_bw, output int o_fw, output int o_fr,
                           output logic [5:0] o_wa, output logic [31:0] o_wd,
                           output logic [5:0] o_ra, output logic o_both);
    o_bw = 0; o_fw = -1; o_fr = -1;
    o_wa = 6'd0; o_wd = 32'd0; o_ra = 6'd0; o_both = 1'b0;
    while (BUSYWAIT && (o_bw < 40)) begin
      if (MEM_WRITE) begin
        if (o_fw < 0) o_fw = o_bw;
        o_wa = MEM_ADDRESS;
        o_wd = MEM_WRITEDATA;
      end
      if (MEM_READ) begin
        if (o_fr < 0) o_fr = o_bw;
        o_ra = MEM_ADDRESS;
      end
      if (MEM_READ && MEM_WRITE) o_both = 1'b1;
      o_bw++;
      @(negedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    ADDRESS = 8'h00; WRITEDATA = 8'h00; mem_rdata_v = 32'd0;

    // reset state, including a request presented while reset is held
    @(negedge CLK); #1;
    READ = 1'b1; ADDRESS = 8'h25; #1;
    check("rst_busywait",  {31'd0, BUSYWAIT},  32'd0);
    check("rst_mem_read",  {31'd0, MEM_READ},  32'd0);
    check("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("rst_mem_addr",  {26'd0, MEM_ADDRESS}, 32'd0);
    check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    check("rst_readdata",  {24'd0, READDATA},  32'd0);

    // clean read miss at 0x25
    @(negedge CLK);
    RESET = 1'b0; mem_rdata_v = 32'h44332211; #1;
    check("miss25_busy",   {31'd0, BUSYWAIT}, 32'd1);
    check("miss25_idle_rd",{31'd0, MEM_READ}, 32'd0);
    wait_fill(bw, first_w, first_r, wa, wd, ra, both);
    check("miss25_bw_cycles", bw, 32'd6);
    check("miss25_no_wb",     first_w, 32'hFFFF_FFFF);
    check("miss25_mem_addr",  {26'd0, ra}, 32'h09);
    check("miss25_readdata",  {24'd0, READDATA}, 32'h22);

    // write hit then read-back
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; WRITEDATA = 8'hAB; #1;
    check("wr25_busy",     {31'd0, BUSYWAIT},  32'd0);
    check("wr25_mem_write",{31'd0, MEM_WRITE}, 32'd0);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; #1;
    check("rd25_data", {24'd0, READDATA}, 32'hAB);
    check("rd25_busy", {31'd0, BUSYWAIT}, 32'd0);

    // dirty conflict miss at 0xA4
    @(negedge CLK);
    ADDRESS = 8'hA4; mem_rdata_v = 32'hDDCCBBAA; #1;
    check("missA4_busy", {31'd0, BUSYWAIT}, 32'd1);
    wait_fill(bw, first_w, first_r, wa, wd, ra, both);
    check("missA4_bw_cycles", bw, 32'd10);
    check("missA4_wb_first",  first_w, 32'd1);
    check("missA4_rd_first",  first_r, 32'd5);
    check("missA4_wb_addr",   {26'd0, wa}, 32'h09);
    check("missA4_wb_data",   wd, 32'h4433AB11);
    check("missA4_rd_addr",   {26'd0, ra}, 32'h29);
    check("missA4_no_overlap",{31'd0, both}, 32'd0);
    check("missA4_readdata",  {24'd0, READDATA}, 32'hAA);

    // READ and WRITE together at 0x10: no request
    @(negedge CLK);
    WRITE = 1'b1; ADDRESS = 8'h10; WRITEDATA = 8'h55; #1;
`ifdef DCACHE_STATS_EN
    check("stats_hits",   {24'd0, HIT_COUNT},  32'd4);
    check("stats_misses", {24'd0, MISS_COUNT}, 32'd2);
`endif
    check("both_busy",  {31'd0, BUSYWAIT},  32'd0);
    check("both_mrd",   {31'd0, MEM_READ},  32'd0);
    check("both_mwr",   {31'd0, MEM_WRITE}, 32'd0);
    @(negedge CLK); #1;
    check("both_busy2", {31'd0, BUSYWAIT},  32'd0);
    check("both_mrd2",  {31'd0, MEM_READ},  32'd0);
    @(negedge CLK);
    WRITE = 1'b0; ADDRESS = 8'hA4; #1;
    check("after_both_rdA4", {24'd0, READDATA}, 32'hAA);
    check("after_both_busy", {31'd0, BUSYWAIT}, 32'd0);

    // write miss at offset 3 (0x0B), then evict it via 0xEB
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h0B; WRITEDATA = 8'h77; mem_rdata_v = 32'h00000000; #1;
    check("wmiss0B_busy", {31'd0, BUSYWAIT}, 32'd1);
    wait_fill(bw, first_w, first_r, wa, wd, ra, both);
    check("wmiss0B_bw_cycles", bw, 32'd6);
    check("wmiss0B_rd_addr",   {26'd0, ra}, 32'h02);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; #1;
    check("rd0B_data", {24'd0, READDATA}, 32'h77);
    @(negedge CLK);
    ADDRESS = 8'hEB; mem_rdata_v = 32'h01020304; #1;
    wait_fill(bw, first_w, first_r, wa, wd, ra, both);
    check("missEB_bw_cycles", bw, 32'd10);
    check("missEB_wb_addr",   {26'd0, wa}, 32'h02);
    check("missEB_wb_data",   wd, 32'h77000000);
    check("missEB_rd_addr",   {26'd0, ra}, 32'h3A);
    check("missEB_readdata",  {24'd0, READDATA}, 32'h01);

    // reset pulse in the middle of a fetch
    @(negedge CLK);
    ADDRESS = 8'h25; mem_rdata_v = 32'h44332211; #1;
    check("rstf_miss_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check("rstf_fetch_rd",   {31'd0, MEM_READ}, 32'd1);
    check("rstf_fetch_addr", {26'd0, MEM_ADDRESS}, 32'h09);
    #2 RESET = 1'b1; #1;
    check("rstf_rd_drop",   {31'd0, MEM_READ}, 32'd0);
    check("rstf_busy_drop", {31'd0, BUSYWAIT}, 32'd0);
    check("rstf_addr_zero", {26'd0, MEM_ADDRESS}, 32'd0);
    check("rstf_readdata",  {24'd0, READDATA}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; #1;
    check("rstf_remiss_busy", {31'd0, BUSYWAIT}, 32'd1);
    wait_fill(bw, first_w, first_r, wa, wd, ra, both);
    check("rstf_bw_cycles", bw, 32'd6);
    check("rstf_no_wb",     first_w, 32'hFFFF_FFFF);
    check("rstf_readdata2", {24'd0, READDATA}, 32'h22);

    @(negedge CLK);
    READ = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
